xrv_id_pipe: RTL and testbench

Second-generation RV32I instruction decode stage with valid/ready handshaking on both sides, replacing the enable-only decoder.
- Decodes opcode, operands, immediates and funct3 from fetch into an output register that EX drains with backpressure.
- Issues early redirects for JAL and, optionally, statically predicted backward branches, then discards wrong-path shadow instructions.
- Flags illegal encodings so EX can trap.

---
 rtl/xrv_pkg.sv | 47 ++++
 rtl/xrv_imm_gen.sv | 77 +++++++
 rtl/xrv_id_pipe.sv | 158 +++++++++++++++
 tb/tb_xrv_id_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xrv_pkg.sv
// Shared RV32I decode definitions: opcode constants, op one-hot bit positions
// and the decoded-instruction record held in the decode output register.
package xrv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int OP_W = 9;

    typedef enum logic [3:0] {
        OPB_LUI    = 4'd0,
        OPB_AUIPC  = 4'd1,
        OPB_JAL    = 4'd2,
        OPB_JALR   = 4'd3,
        OPB_BRANCH = 4'd4,
        OPB_LOAD   = 4'd5,
        OPB_STORE  = 4'd6,
        OPB_IMM    = 4'd7,
        OPB_REG    = 4'd8
    } op_bit_e;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic            is_compressed;
        logic [31:0]     imm_signed;
        logic [31:0]     imm_unsigned;
        logic [4:0]      src1;
        logic [4:0]      src2;
        logic [4:0]      dest;
        logic [7:0]      funct3;
        logic            funct7_bit5;
        logic            pred_taken;
        logic            illegal;
    } dec_t;

    function automatic logic [7:0] funct3_onehot(input logic [2:0] f3);
        return 8'h01 << f3;
    endfunction

endpackage

// File: rtl/xrv_imm_gen.sv
// Combinational RV32I classifier: opcode one-hot, sign/zero-extended immediate
// and illegal-encoding flag for one 32-bit instruction word.
module xrv_imm_gen
    import xrv_pkg::*;
#(
    parameter bit ILLEGAL_CHECK = 1'b1
) (
    input  logic [31:0]     inst,
    output logic [31:0]     imm_signed,
    output logic [31:0]     imm_unsigned,
    output logic [OP_W-1:0] op,
    output logic            illegal
);

    logic known_s;

    // The opcode field includes inst[1:0], so a non-11 low pair never matches.
    always_comb begin
        imm_signed   = 32'h0000_0000;
        imm_unsigned = 32'h0000_0000;
        op           = 9'h000;
        known_s      = 1'b1;
        case (inst[6:0])
            OP_LUI, OP_AUIPC: begin
                imm_signed   = {inst[31:12], 12'h000};
                imm_unsigned = {inst[31:12], 12'h000};
                if (inst[6:0] == OP_LUI) begin
                    op[OPB_LUI] = 1'b1;
                end else begin
                    op[OPB_AUIPC] = 1'b1;
                end
            end
            OP_JAL: begin
                imm_signed   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                imm_unsigned = {11'h000, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                op[OPB_JAL]  = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                imm_signed   = {{20{inst[31]}}, inst[31:20]};
                imm_unsigned = {20'h00000, inst[31:20]};
                if (inst[6:0] == OP_JALR) begin
                    op[OPB_JALR] = 1'b1;
                end else if (inst[6:0] == OP_LOAD) begin
                    op[OPB_LOAD] = 1'b1;
                end else begin
                    op[OPB_IMM] = 1'b1;
                end
            end
            OP_BRANCH: begin
                imm_signed     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                imm_unsigned   = {19'h00000, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                op[OPB_BRANCH] = 1'b1;
            end
            OP_STORE: begin
                imm_signed    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                imm_unsigned  = {20'h00000, inst[31:25], inst[11:7]};
                op[OPB_STORE] = 1'b1;
            end
            OP_REG: begin
                op[OPB_REG] = 1'b1;
            end
            default: begin
                known_s = 1'b0;
            end
        endcase
    end

    // Illegal flag is only meaningful when checking is built in.
    always_comb begin
        if (ILLEGAL_CHECK) begin
            illegal = ~known_s;
        end else begin
            illegal = 1'b0;
        end
    end

endmodule

// File: rtl/xrv_id_pipe.sv
// RV32I decode stage with valid/ready on both sides, early JAL / backward-branch
// redirect to fetch and discard of the wrong-path shadow instructions.
module xrv_id_pipe
    import xrv_pkg::*;
#(
    parameter bit          BRANCH_PREDICT = 1'b1,
    parameter int unsigned SHADOW         = 1,
    parameter bit          ILLEGAL_CHECK  = 1'b1
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [31:0]     inst_pc,
    input  logic            inst_is_compressed,
    output logic            redir_valid,
    output logic [31:0]     redir_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_pc,
    output logic [OP_W-1:0] op,
    output logic            op_is_compressed,
    output logic [31:0]     imm_signed,
    output logic [31:0]     imm_unsigned,
    output logic [4:0]      src1,
    output logic [4:0]      src2,
    output logic [4:0]      dest,
    output logic [7:0]      funct3,
    output logic            funct7_bit5,
    output logic            pred_taken,
    output logic            illegal
);

    localparam logic [1:0] SHADOW_LD = 2'(SHADOW);

    logic [31:0]     gen_imm_signed_s;
    logic [31:0]     gen_imm_unsigned_s;
    logic [OP_W-1:0] gen_op_s;
    logic            gen_illegal_s;

    logic accept_s;
    logic fwd_s;
    logic bwd_branch_s;
    logic trigger_s;

    logic        out_valid_q,   out_valid_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_addr_q,  redir_addr_d;
    logic [1:0]  shadow_q,      shadow_d;
    logic [31:0] pc_q,          pc_d;
    dec_t        dec_q,         dec_d;

    xrv_imm_gen #(
        .ILLEGAL_CHECK (ILLEGAL_CHECK)
    ) u_imm_gen (
        .inst         (inst),
        .imm_signed   (gen_imm_signed_s),
        .imm_unsigned (gen_imm_unsigned_s),
        .op           (gen_op_s),
        .illegal      (gen_illegal_s)
    );

    assign in_ready     = ~out_valid_q | out_ready;
    assign accept_s     = in_valid & in_ready & ~flush;
    assign fwd_s        = accept_s & (shadow_q == 2'd0);
    assign bwd_branch_s = BRANCH_PREDICT & gen_op_s[OPB_BRANCH] & gen_imm_signed_s[31];
    assign trigger_s    = fwd_s & (gen_op_s[OPB_JAL] | bwd_branch_s);

    // Shadow instructions are consumed from fetch but never reach EX or redirect.
    always_comb begin
        out_valid_d   = out_valid_q;
        redir_valid_d = 1'b0;
        redir_addr_d  = redir_addr_q;
        shadow_d      = shadow_q;
        if (flush) begin
            out_valid_d = 1'b0;
            shadow_d    = 2'd0;
        end else begin
            if (fwd_s) begin
                out_valid_d = 1'b1;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            if (trigger_s) begin
                redir_valid_d = 1'b1;
                redir_addr_d  = inst_pc + gen_imm_signed_s;
                shadow_d      = SHADOW_LD;
            end else if (accept_s && (shadow_q != 2'd0)) begin
                shadow_d = shadow_q - 2'd1;
            end else begin
                shadow_d = shadow_q;
            end
        end
    end

    // Payload captures only instructions that are actually forwarded.
    always_comb begin
        pc_d  = pc_q;
        dec_d = dec_q;
        if (fwd_s) begin
            pc_d                = inst_pc;
            dec_d.op            = gen_op_s;
            dec_d.is_compressed = inst_is_compressed;
            dec_d.imm_signed    = gen_imm_signed_s;
            dec_d.imm_unsigned  = gen_imm_unsigned_s;
            dec_d.src1          = inst[19:15];
            dec_d.src2          = inst[24:20];
            dec_d.dest          = inst[11:7];
            dec_d.funct3        = funct3_onehot(inst[14:12]);
            dec_d.funct7_bit5   = inst[30];
            dec_d.pred_taken    = bwd_branch_s;
            dec_d.illegal       = gen_illegal_s;
        end else begin
            pc_d  = pc_q;
            dec_d = dec_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_valid_q   <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_addr_q  <= 32'h0000_0000;
            shadow_q      <= 2'd0;
            pc_q          <= 32'h0000_0000;
            dec_q         <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            redir_valid_q <= redir_valid_d;
            redir_addr_q  <= redir_addr_d;
            shadow_q      <= shadow_d;
            pc_q          <= pc_d;
            dec_q         <= dec_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign redir_valid      = redir_valid_q;
    assign redir_addr       = redir_addr_q;
    assign out_pc           = pc_q;
    assign op               = dec_q.op;
    assign op_is_compressed = dec_q.is_compressed;
    assign imm_signed       = dec_q.imm_signed;
    assign imm_unsigned     = dec_q.imm_unsigned;
    assign src1             = dec_q.src1;
    assign src2             = dec_q.src2;
    assign dest             = dec_q.dest;
    assign funct3           = dec_q.funct3;
    assign funct7_bit5      = dec_q.funct7_bit5;
    assign pred_taken       = dec_q.pred_taken;
    assign illegal          = dec_q.illegal;

endmodule

// File: tb/tb_xrv_id_pipe.sv
// Bench for xrv_id_pipe: decode vector table, directed handshake/redirect
// sequences and random traffic against a transaction-level reference model.
module tb_xrv_id_pipe;

    localparam int SHADOW_N = 1;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = 32'h0;
    logic [31:0] inst_pc = 32'h0;
    logic        inst_is_compressed = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, redir_valid, out_valid, op_is_compressed, funct7_bit5, pred_taken, illegal;
    logic [31:0] redir_addr, out_pc, imm_signed, imm_unsigned;
    logic [8:0]  op;
    logic [4:0]  src1, src2, dest;
    logic [7:0]  funct3;

    logic        nbp_in_ready, nbp_redir_valid, nbp_out_valid, nbp_op_is_compressed, nbp_funct7_bit5, nbp_pred_taken, nbp_illegal;
    logic [31:0] nbp_redir_addr, nbp_out_pc, nbp_imm_signed, nbp_imm_unsigned;
    logic [8:0]  nbp_op;
    logic [4:0]  nbp_src1, nbp_src2, nbp_dest;
    logic [7:0]  nbp_funct3;

    xrv_id_pipe #(.BRANCH_PREDICT(1'b1), .SHADOW(SHADOW_N), .ILLEGAL_CHECK(1'b1)) dut (
        .clk(clk), .rstb(rstb), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_is_compressed(inst_is_compressed),
        .redir_valid(redir_valid), .redir_addr(redir_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .op(op), .op_is_compressed(op_is_compressed),
        .imm_signed(imm_signed), .imm_unsigned(imm_unsigned), .src1(src1), .src2(src2),
        .dest(dest), .funct3(funct3), .funct7_bit5(funct7_bit5), .pred_taken(pred_taken),
        .illegal(illegal)
    );

    xrv_id_pipe #(.BRANCH_PREDICT(1'b0), .SHADOW(SHADOW_N), .ILLEGAL_CHECK(1'b1)) dut_nbp (
        .clk(clk), .rstb(rstb), .flush(flush), .in_valid(in_valid), .in_ready(nbp_in_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_is_compressed(inst_is_compressed),
        .redir_valid(nbp_redir_valid), .redir_addr(nbp_redir_addr), .out_valid(nbp_out_valid),
        .out_ready(out_ready), .out_pc(nbp_out_pc), .op(nbp_op), .op_is_compressed(nbp_op_is_compressed),
        .imm_signed(nbp_imm_signed), .imm_unsigned(nbp_imm_unsigned), .src1(nbp_src1), .src2(nbp_src2),
        .dest(nbp_dest), .funct3(nbp_funct3), .funct7_bit5(nbp_funct7_bit5), .pred_taken(nbp_pred_taken),
        .illegal(nbp_illegal)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [8:0]  op;
        logic [31:0] ims;
        logic [31:0] imu;
        logic        ill;
    } ref_t;

    // Decode from the ISA tables: raw immediate value and its field width,
    // sign handled arithmetically.
    function automatic ref_t ref_decode(input logic [31:0] i);
        ref_t r;
        int w;
        logic [31:0] raw;
        r.op = 9'h0; r.ill = 1'b0; w = 0; raw = 32'h0;
        case (i[6:0])
            7'h37: begin r.op = 9'h001; raw = i & 32'hFFFF_F000; w = 32; end
            7'h17: begin r.op = 9'h002; raw = i & 32'hFFFF_F000; w = 32; end
            7'h6F: begin
                r.op = 9'h004; w = 21;
                raw = (32'(i[31]) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            end
            7'h67: begin r.op = 9'h008; raw = i >> 20; w = 12; end
            7'h63: begin
                r.op = 9'h010; w = 13;
                raw = (32'(i[31]) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            end
            7'h03: begin r.op = 9'h020; raw = i >> 20; w = 12; end
            7'h23: begin r.op = 9'h040; raw = (32'(i[31:25]) << 5) | 32'(i[11:7]); w = 12; end
            7'h13: begin r.op = 9'h080; raw = i >> 20; w = 12; end
            7'h33: begin r.op = 9'h100; end
            default: r.ill = 1'b1;
        endcase
        r.imu = raw;
        if (w > 0 && w < 32 && raw[w-1]) r.ims = raw - (32'd1 << w);
        else                             r.ims = raw;
        return r;
    endfunction

    ref_t r_dec;
    logic m_acc, m_taken;
    logic m_valid, m_redir, m_comp, m_f7, m_pred, m_ill;
    logic [31:0] m_raddr, m_pc, m_ims, m_imu;
    logic [8:0] m_op;
    logic [4:0] m_src1, m_src2, m_dest;
    logic [7:0] m_f3;
    int m_shadow;

    always_comb begin
        r_dec   = ref_decode(inst);
        m_acc   = in_valid && (!m_valid || out_ready) && !flush;
        m_taken = (r_dec.op == 9'h004) || ((r_dec.op == 9'h010) && ($signed(r_dec.ims) < 0));
    end

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_valid <= 0; m_redir <= 0; m_raddr <= 0; m_shadow <= 0; m_pc <= 0;
            m_op <= 0; m_comp <= 0; m_ims <= 0; m_imu <= 0; m_src1 <= 0; m_src2 <= 0;
            m_dest <= 0; m_f3 <= 0; m_f7 <= 0; m_pred <= 0; m_ill <= 0;
        end else begin
            m_redir <= 1'b0;
            if (flush) begin
                m_valid  <= 1'b0;
                m_shadow <= 0;
            end else if (m_acc && m_shadow > 0) begin
                m_shadow <= m_shadow - 1;
                if (out_ready) m_valid <= 1'b0;
            end else if (m_acc) begin
                m_valid <= 1'b1;
                m_pc <= inst_pc; m_op <= r_dec.op; m_comp <= inst_is_compressed;
                m_ims <= r_dec.ims; m_imu <= r_dec.imu; m_ill <= r_dec.ill;
                m_src1 <= inst[19:15]; m_src2 <= inst[24:20]; m_dest <= inst[11:7];
                m_f3 <= 8'd1 << inst[14:12]; m_f7 <= inst[30];
                m_pred <= m_taken && (r_dec.op == 9'h010);
                if (m_taken) begin
                    m_redir  <= 1'b1;
                    m_raddr  <= inst_pc + r_dec.ims;
                    m_shadow <= SHADOW_N;
                end
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Registered outputs against the model, every cycle away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m.out_valid", out_valid, m_valid);
            chk("m.redir_valid", redir_valid, m_redir);
            chk("m.redir_addr", redir_addr, m_raddr);
            chk("m.out_pc", out_pc, m_pc);
            chk("m.op", op, m_op);
            chk("m.op_is_compressed", op_is_compressed, m_comp);
            chk("m.imm_signed", imm_signed, m_ims);
            chk("m.imm_unsigned", imm_unsigned, m_imu);
            chk("m.regs", {src1, src2, dest}, {m_src1, m_src2, m_dest});
            chk("m.funct3", funct3, m_f3);
            chk("m.funct7_bit5", funct7_bit5, m_f7);
            chk("m.pred_taken", pred_taken, m_pred);
            chk("m.illegal", illegal, m_ill);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [8:0]  op;
        logic [31:0] ims;
        logic [31:0] imu;
        logic        ill;
        logic        redir;
        logic [31:0] raddr;
        logic        pred;
        logic        nbp_redir;
    } vec_t;

    localparam int NV = 13;
    vec_t vec [NV];

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_JAL  = 32'h0100_006F;
    localparam logic [31:0] I_ADD  = 32'h0020_81B3;

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] pc);
        in_valid = v; inst = i; inst_pc = pc;
    endtask

    initial begin
        vec[0]  = '{32'h0050_0093, 32'h000, 9'h080, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vec[1]  = '{32'h0100_006F, 32'h100, 9'h004, 32'h0000_0010, 32'h0000_0010, 1'b0, 1'b1, 32'h110, 1'b0, 1'b1};
        vec[2]  = '{32'hFE00_0CE3, 32'h200, 9'h010, 32'hFFFF_FFF8, 32'h0000_1FF8, 1'b0, 1'b1, 32'h1F8, 1'b1, 1'b0};
        vec[3]  = '{32'h1234_52B7, 32'h010, 9'h001, 32'h1234_5000, 32'h1234_5000, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vec[4]  = '{32'hFFFF_F117, 32'h014, 9'h002, 32'hFFFF_F000, 32'hFFFF_F000, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vec[5]  = '{32'hFFC1_2083, 32'h018, 9'h020, 32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vec[6]  = '{32'hFE31_2E23, 32'h01C, 9'h040, 32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vec[7]  = '{32'h7FF2_80E7, 32'h020, 9'h008, 32'h0000_07FF, 32'h0000_07FF, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vec[8]  = '{32'h0020_81B3, 32'h024, 9'h100, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vec[9]  = '{32'h0000_0000, 32'h028, 9'h000, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 1'b0};
        vec[10] = '{32'h0000_007F, 32'h02C, 9'h000, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 1'b0};
        vec[11] = '{32'h0020_9463, 32'h030, 9'h010, 32'h0000_0008, 32'h0000_0008, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vec[12] = '{32'hFFDF_F06F, 32'h300, 9'h004, 32'hFFFF_FFFC, 32'h001F_FFFC, 1'b0, 1'b1, 32'h2FC, 1'b0, 1'b1};

        // Reset held with fetch offering an instruction.
        #1 rstb = 1'b0;
        drive(1'b1, I_ADDI, 32'h0);
        #1 chk_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.redir_valid", redir_valid, 0);
        chk("rst.payload", {op, imm_signed, out_pc, funct3, dest}, 64'h0);
        chk("rst.in_ready", in_ready, 1);
        rstb = 1'b1;
        @(negedge clk);
        drive(1'b0, I_ADDI, 32'h0);
        chk("rst.first_valid", out_valid, 1);
        chk("rst.first_op", op, 9'h080);
        chk("rst.first_imm", imm_signed, 32'd5);
        chk("rst.first_dest", dest, 5'd1);
        chk("rst.first_funct3", funct3, 8'h01);
        chk("rst.first_pc", out_pc, 32'h0);

        // Decode table, each entry followed by a flush to clear any shadow.
        for (int k = 0; k < NV; k++) begin
            drive(1'b1, vec[k].inst, vec[k].pc);
            @(negedge clk);
            in_valid = 1'b0;
            chk("vec.out_valid", out_valid, 1);
            chk("vec.op", op, vec[k].op);
            chk("vec.imm_signed", imm_signed, vec[k].ims);
            chk("vec.imm_unsigned", imm_unsigned, vec[k].imu);
            chk("vec.illegal", illegal, vec[k].ill);
            chk("vec.redir_valid", redir_valid, vec[k].redir);
            if (vec[k].redir) chk("vec.redir_addr", redir_addr, vec[k].raddr);
            chk("vec.pred_taken", pred_taken, vec[k].pred);
            chk("vec.nbp_redir", nbp_redir_valid, vec[k].nbp_redir);
            chk("vec.nbp_pred", nbp_pred_taken, 0);
            chk("vec.nbp_valid", nbp_out_valid, 1);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end

        // JAL redirect and single-instruction shadow.
        drive(1'b1, I_JAL, 32'h100);
        @(negedge clk);
        chk("jal.redir", redir_valid, 1);
        chk("jal.addr", redir_addr, 32'h110);
        chk("jal.pc", out_pc, 32'h100);
        drive(1'b1, I_ADDI, 32'h104);
        @(negedge clk);
        chk("jal.pulse_end", redir_valid, 0);
        chk("jal.shadow_drop", out_valid, 0);
        drive(1'b1, I_ADDI, 32'h108);
        @(negedge clk);
        chk("jal.after_shadow", {out_valid, out_pc}, {1'b1, 32'h108});
        in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: three stalled cycles, then drain.
        drive(1'b1, I_ADDI, 32'h400);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, I_ADD, 32'h404);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp.in_ready", in_ready, 0);
            @(negedge clk);
            chk("bp.hold", {out_valid, out_pc}, {1'b1, 32'h400});
        end
        out_ready = 1'b1;
        #1 chk("bp.release_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.next", {out_valid, out_pc, op}, {1'b1, 32'h404, 9'h100});
        @(negedge clk);
        chk("bp.no_dup", out_valid, 0);

        // Flush collides with an offered JAL.
        flush = 1'b1;
        drive(1'b1, I_JAL, 32'h500);
        @(negedge clk);
        flush = 1'b0;
        chk("fl.redir", redir_valid, 0);
        chk("fl.valid", out_valid, 0);
        drive(1'b1, I_ADDI, 32'h504);
        @(negedge clk);
        in_valid = 1'b0;
        chk("fl.no_shadow", {out_valid, out_pc}, {1'b1, 32'h504});
        @(negedge clk);

        // Reset arriving while a redirect pulse is out.
        drive(1'b1, I_JAL, 32'h600);
        @(posedge clk);
        #2 chk("rm.pulse", redir_valid, 1);
        rstb = 1'b0;
        #1 chk("rm.lost", {redir_valid, out_valid, redir_addr}, 34'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rstb = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            flush              = ($urandom_range(0, 15) == 0);
            out_ready          = ($urandom_range(0, 2) != 0);
            inst_is_compressed = $urandom_range(0, 1) == 1;
            inst_pc            = $urandom & 32'hFFFF_FFFE;
            if ($urandom_range(0, 3) == 0) inst = $urandom;
            else inst = vec[$urandom_range(0, NV - 1)].inst ^ ($urandom & 32'h400F_8F80);
            in_valid           = ($urandom_range(0, 3) != 0);
            #1 chk("rnd.in_ready", in_ready, !m_valid || out_ready);
        end
        in_valid = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
